// File: rtl/gradient_pkg.sv
// gradient_pkg: shared constants, scheduler state type and line-count helper
package gradient_pkg;
  localparam int DATALINE_SIZE = 16;
  localparam int FLOAT_SIZE = 32;
  typedef enum logic {IDLE, STREAM} sched_state_t;
  // ceil(n / 2^lg) computed in 33 bits so n near 2^32 cannot wrap
  function automatic logic [32:0] lines_for_n(input logic [31:0] n, input int unsigned lg);
    return ({1'b0, n} + ((33'd1 << lg) - 33'd1)) >> lg;
  endfunction
endpackage

// File: rtl/gradient_credit_counter.sv
// gradient_credit_counter: batches in flight, completed gradients, underflow flag
module gradient_credit_counter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  output logic [3:0]           outstanding,
  output logic [CNT_WIDTH-1:0] done_count,
  output logic                 err_underflow,
  output logic                 full
);
  logic dec_ok;
  assign dec_ok = dec & (outstanding != 4'd0);
  assign full = outstanding >= 4'(MAX_OUTSTANDING);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      outstanding <= '0;
      done_count <= '0;
      err_underflow <= 1'b0;
    end else begin
      outstanding <= outstanding + 4'(inc) - 4'(dec_ok);
      done_count <= done_count + CNT_WIDTH'(dec_ok);
      if (dec & ~dec_ok) err_underflow <= 1'b1;
    end
endmodule

// File: rtl/gradient_batch_scheduler.sv
// gradient_batch_scheduler: frames rx datalines into N-sized batches for the gradient calculator.
// Optional stall watchdog (err_timeout) enabled by defining GRAD_SCHED_TIMEOUT_EN.
module gradient_batch_scheduler #(
  parameter int DATALINE_SIZE = 16,
  parameter int DATA_WIDTH = 512,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cfg_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_rx_data_TDATA,
  input  logic                  s_axis_rx_data_TVALID,
  output logic                  s_axis_rx_data_TREADY,
  output logic [DATA_WIDTH-1:0] m_axis_tx_data_TDATA,
  output logic                  m_axis_tx_data_TVALID,
  output logic                  m_axis_tx_data_TLAST,
  input  logic                  m_axis_tx_data_TREADY,
  output logic [31:0]           m_N,
  input  logic                  grad_TVALID,
  output logic [3:0]            outstanding,
  output logic [CNT_WIDTH-1:0]  done_count,
  output logic                  busy,
`ifdef GRAD_SCHED_TIMEOUT_EN
  output logic                  err_timeout,
`endif
  output logic                  err_zero_n,
  output logic                  err_underflow
);
  import gradient_pkg::*;
  sched_state_t state, state_nxt;
  logic [31:0] line_cnt, lines_total;
  logic hs, last, accept, full, timeout;
  always_comb begin
    busy = state == STREAM;
    cfg_ready = rst & ~busy & ~full;
    s_axis_rx_data_TREADY = busy & m_axis_tx_data_TREADY;
    m_axis_tx_data_TVALID = busy & s_axis_rx_data_TVALID;
    m_axis_tx_data_TDATA = s_axis_rx_data_TDATA;
    m_axis_tx_data_TLAST = busy & (line_cnt == lines_total - 32'd1);
    hs = m_axis_tx_data_TVALID & m_axis_tx_data_TREADY;
    last = hs & m_axis_tx_data_TLAST;
    accept = cfg_valid & cfg_ready & (cfg_n != 32'd0);
    state_nxt = busy ? ((last | timeout) ? IDLE : STREAM) : (accept ? STREAM : IDLE);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      line_cnt <= '0;
      lines_total <= '0;
      m_N <= '0;
      err_zero_n <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        m_N <= cfg_n;
        lines_total <= 32'(lines_for_n(cfg_n, $clog2(DATALINE_SIZE)));
      end
      if (cfg_valid & cfg_ready & (cfg_n == 32'd0)) err_zero_n <= 1'b1;
      line_cnt <= (accept | last | timeout) ? '0 : line_cnt + 32'(hs);
    end
`ifdef GRAD_SCHED_TIMEOUT_EN
  logic [15:0] stall;
  assign timeout = busy & ~hs & (stall == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall <= '0;
      err_timeout <= 1'b0;
    end else begin
      stall <= (busy & ~hs & ~timeout) ? stall + 16'd1 : '0;
      if (timeout) err_timeout <= 1'b1;
    end
`else
  assign timeout = 1'b0;
`endif
  gradient_credit_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .CNT_WIDTH(CNT_WIDTH)) u_credit (
    .clk(clk),
    .rst(rst),
    .inc(last),
    .dec(grad_TVALID),
    .outstanding(outstanding),
    .done_count(done_count),
    .err_underflow(err_underflow),
    .full(full)
  );
endmodule

// File: tb/tb_gradient_batch_scheduler.sv
// tb_gradient_batch_scheduler: directed and randomized batches checked against a batch-level model
module tb_gradient_batch_scheduler;
  localparam int MAXO = 2;
  localparam int DS = 16;
  logic clk, rst;
  logic [31:0] cfg_n;
  logic cfg_valid, cfg_ready;
  logic [511:0] s_data, m_data;
  logic s_valid, s_ready, m_valid, m_last, m_ready;
  logic [31:0] m_n;
  logic grad;
  logic [3:0] outstanding;
  logic [31:0] done_count;
  logic busy, err_zero_n, err_underflow;
  int checks = 0, errors = 0;
  bit mst, mez, meu, exp_cr, last_cfg_hs;
  longint mrem;
  logic [31:0] mn, mdone;
  int mout;

  gradient_batch_scheduler #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .cfg_n(cfg_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .s_axis_rx_data_TDATA(s_data), .s_axis_rx_data_TVALID(s_valid), .s_axis_rx_data_TREADY(s_ready),
    .m_axis_tx_data_TDATA(m_data), .m_axis_tx_data_TVALID(m_valid), .m_axis_tx_data_TLAST(m_last),
    .m_axis_tx_data_TREADY(m_ready), .m_N(m_n), .grad_TVALID(grad), .outstanding(outstanding),
    .done_count(done_count), .busy(busy), .err_zero_n(err_zero_n), .err_underflow(err_underflow)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mst = 0; mrem = 0; mn = 0; mout = 0; mdone = 0; mez = 0; meu = 0;
  endtask

  task automatic chk_reset();
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_tready", s_ready, 0);
    chk("rst_tvalid", m_valid, 0);
    chk("rst_tlast", m_last, 0);
    chk("rst_m_n", m_n, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_done", done_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_zero", err_zero_n, 0);
    chk("rst_err_under", err_underflow, 0);
  endtask

  task automatic rand_data();
    for (int i = 0; i < 16; i++) s_data[i*32 +: 32] = $urandom;
  endtask

  // one clock: check outputs for the driven inputs, then advance the model
  task automatic cyc();
    bit d_hs, lst;
    #1;
    exp_cr = !mst && mout < MAXO;
    chk("cfg_ready", cfg_ready, exp_cr);
    chk("s_tready", s_ready, mst & m_ready);
    chk("m_tvalid", m_valid, mst & s_valid);
    chk("m_tlast", m_last, mst && mrem == 1);
    if (mst && s_valid) chk("m_tdata", m_data, s_data);
    chk("m_n", m_n, mn);
    chk("outstanding", outstanding, 4'(mout));
    chk("done_count", done_count, mdone);
    chk("busy", busy, mst);
    chk("err_zero_n", err_zero_n, mez);
    chk("err_underflow", err_underflow, meu);
    @(posedge clk);
    last_cfg_hs = cfg_valid && exp_cr;
    d_hs = mst && s_valid && m_ready;
    lst = d_hs && mrem == 1;
    if (last_cfg_hs) begin
      if (cfg_n == 0) mez = 1;
      else begin mst = 1; mrem = (longint'(cfg_n) + DS - 1) / DS; mn = cfg_n; end
    end
    if (d_hs) mrem--;
    if (lst) mst = 0;
    if (grad && mout == 0) begin
      meu = 1;
      mout += int'(lst);
    end else begin
      mout = mout + int'(lst) - int'(grad);
      mdone += 32'(grad);
    end
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] n, input bit rg);
    int b = 0;
    cfg_valid = 1; cfg_n = n;
    do begin
      grad = rg && mout > 0 && $urandom_range(0, 2) == 0;
      cyc();
      b++;
    end while (!last_cfg_hs && b < 50);
    chk("cfg_accept", last_cfg_hs, 1);
    cfg_valid = 0; grad = 0;
  endtask

  task automatic stream(input int pv, input int pr, input bit rg);
    int b = 0;
    while (mst && b < 3000) begin
      s_valid = $urandom_range(0, 99) < pv;
      m_ready = $urandom_range(0, 99) < pr;
      grad = rg && mout > 0 && $urandom_range(0, 3) == 0;
      rand_data();
      cyc();
      b++;
    end
    chk("stream_done", mst, 0);
    s_valid = 0; m_ready = 0; grad = 0;
  endtask

  initial begin
    rst = 0; cfg_n = 0; cfg_valid = 0; s_data = 0; s_valid = 0; m_ready = 1; grad = 0;
    model_reset();
    #2;
    chk_reset();
    @(negedge clk); @(negedge clk);
    rst = 1; m_ready = 0;
    cyc(); cyc();
    // 64 samples -> 4 back-to-back lines
    offer(64, 0);
    stream(100, 100, 0);
    cyc();
    // 17 samples -> 2 lines under alternating ready
    offer(17, 0);
    for (int k = 0; k < 20 && mst; k++) begin
      s_valid = 1; m_ready = (k % 2 == 0); rand_data();
      cyc();
    end
    chk("t2_done", mst, 0);
    s_valid = 0; m_ready = 0;
    // credits exhausted: offer is refused until a gradient returns
    cfg_valid = 1; cfg_n = 16;
    cyc(); cyc(); cyc();
    grad = 1; cyc(); grad = 0;
    offer(16, 0);
    // TLAST and gradient in the same cycle
    s_valid = 1; m_ready = 1; grad = 1; rand_data();
    cyc();
    s_valid = 0; m_ready = 0; grad = 0;
    cyc();
    // zero-length batch, then underflow
    offer(0, 0);
    cyc();
    grad = 1; cyc(); cyc(); grad = 0;
    cyc();
    // randomized batches
    for (int t = 0; t < 25; t++) begin
      offer($urandom_range(1, 80), 1);
      stream($urandom_range(30, 100), $urandom_range(30, 100), 1);
    end
    grad = (mout > 0); cyc(); grad = 0;
    // reset after 3 of 8 lines
    offer(128, 0);
    for (int k = 0; k < 3; k++) begin
      s_valid = 1; m_ready = 1; rand_data();
      cyc();
    end
    chk("mid_busy", busy, 1);
    #2 rst = 0;
    #1;
    model_reset();
    chk_reset();
    s_valid = 0; m_ready = 0;
    @(negedge clk);
    rst = 1;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gradient_batch_scheduler.md
Name: gradient_batch_scheduler

Overview:
- Sequences 512-bit datalines from the TCP rx stream into batch_gradient_calculator.
- Per batch: accepts the sample count N from the host, forwards exactly ceil(N/DATALINE_SIZE) lines, and asserts TLAST on the final line.
- Holds N stable on the calculator's N input until that batch's TLAST has been accepted.
- Bounds batches in flight (TLAST sent, gradient not yet returned) with a credit counter; counts completed gradients for host polling.

Parameters:
DATALINE_SIZE, 16, floats per 512-bit dataline; power of two.
DATA_WIDTH, 512, dataline width in bits.
MAX_OUTSTANDING, 4, maximum batches in flight; range 1..15.
CNT_WIDTH, 32, width of the completed-batch counter.
TIMEOUT_CYCLES, 65535, stall watchdog limit (optional feature only).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
cfg_n  in  32  samples in the next batch (N)
cfg_valid  in  1  cfg_n is valid
cfg_ready  out  1  scheduler accepts cfg_n
s_axis_rx_data_TDATA  in  512  dataline from network
s_axis_rx_data_TVALID  in  1  network data valid
s_axis_rx_data_TREADY  out  1  scheduler accepts dataline
m_axis_tx_data_TDATA  out  512  dataline to calculator
m_axis_tx_data_TVALID  out  1  to calculator
m_axis_tx_data_TLAST  out  1  last line of batch
m_axis_tx_data_TREADY  in  1  calculator ready (its s_axis_rx_data_TREADY)
m_N  out  32  N for the current batch, to the calculator's N input
grad_TVALID  in  1  calculator batch_gradient_TVALID; one pulse per batch
outstanding  out  4  batches in flight
done_count  out  CNT_WIDTH  completed gradients; wraps at 2^CNT_WIDTH
busy  out  1  state is STREAM
err_zero_n  out  1  sticky: cfg_n==0 was offered
err_underflow  out  1  sticky: grad_TVALID arrived with outstanding==0

Behaviour:
- Reset (rst low, asynchronous assert, synchronous deassert outside the block):
  - state=IDLE; line_cnt=0; lines_total=0; m_N=0; outstanding=0; done_count=0.
  - All error flags 0; cfg_ready=0 while reset is asserted.
- States:
  - IDLE:
    - cfg_ready = (outstanding < MAX_OUTSTANDING).
    - On cfg_valid & cfg_ready & cfg_n!=0: m_N<=cfg_n; lines_total<=(cfg_n+DATALINE_SIZE-1)>>log2(DATALINE_SIZE), computed in 33 bits with no overflow; line_cnt<=0; next state STREAM.
    - On cfg_valid & cfg_ready & cfg_n==0: the value is consumed and dropped; err_zero_n<=1; stay in IDLE.
  - STREAM:
    - cfg_ready=0.
    - Combinational pass-through, zero latency: m_TDATA=s_TDATA; m_TVALID=s_TVALID; s_TREADY=m_TREADY.
    - TLAST = (line_cnt==lines_total-1).
    - On each handshake (m_TVALID & m_TREADY): line_cnt++.
    - On the handshake where TLAST=1: line_cnt<=0, outstanding++, next state IDLE.
  - Outside STREAM: s_TREADY=0; m_TVALID=0; m_TLAST=0; m_TDATA is don't-care.
- m_N is held from the IDLE acceptance until the next acceptance. It is therefore stable on and after the TLAST beat, as the calculator's converter requires.
- Credits:
  - TLAST handshake alone: outstanding+1.
  - grad_TVALID alone: outstanding-1 and done_count+1.
  - Both in the same cycle: outstanding unchanged; done_count+1.
  - grad_TVALID with outstanding==0: outstanding stays 0; done_count unchanged; err_underflow<=1.
  - outstanding==MAX_OUTSTANDING forces cfg_ready=0. The new batch starts on the cycle after a credit returns.
- Reset asserted mid-batch: partial batch abandoned, all state cleared. Upstream must resynchronise.
- Error flags clear only on reset.

Optional Feature:
- Macro GRAD_SCHED_TIMEOUT_EN.
- Defined:
  - Adds output err_timeout (1 bit, sticky) and an internal 16-bit stall counter.
  - In STREAM, the counter increments each cycle without a handshake and resets on any handshake.
  - On reaching TIMEOUT_CYCLES: err_timeout<=1; state is forced to IDLE; line_cnt<=0; outstanding unchanged.
- Undefined: port and logic absent; STREAM waits indefinitely.

Decomposition:
- Package gradient_pkg holds:
  - DATALINE_SIZE and FLOAT_SIZE constants.
  - sched_state_t enum {IDLE, STREAM}.
  - A lines_for_n() function.
- Sub-module gradient_credit_counter holds:
  - outstanding, done_count and err_underflow.
  - Inputs inc, dec; output full.

Test Plan:
- cfg_n=64, then 4 back-to-back lines with m_TREADY=1 -> TLAST on the 4th line only; m_N=64 throughout; outstanding=1; return to IDLE.
- cfg_n=17 -> 2 lines, TLAST on the 2nd; m_TREADY toggling 1010 -> no line lost or duplicated; TLAST beat is the 2nd handshake.
- MAX_OUTSTANDING=2; issue 2 batches of N=16 with no grad_TVALID -> cfg_ready=0. Pulse grad_TVALID -> cfg_ready=1 the next cycle; outstanding=1; done_count=1.
- TLAST handshake and grad_TVALID in the same cycle with outstanding=1 -> outstanding stays 1; done_count+1.
- cfg_n=0 -> err_zero_n=1; state IDLE; no lines accepted. grad_TVALID at outstanding=0 -> err_underflow=1; done_count unchanged.
- Assert rst after 3 of 8 lines (N=128) -> all outputs return to reset values immediately. With GRAD_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=100, a stall of 100 cycles -> err_timeout=1, state IDLE.
